instr_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the 8-bit program counter. Consumes the PC value, issues synchronous reads to program memory and buffers returned instructions in a 2-entry queue, tagged with their PC.
- Presents instructions to decode over a valid/ready handshake.
- Drives the PC's increment enable, load enable and load value, including redirects for jump, call and branch requests.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
// NOP is the all-zero instruction word.
package cpu_pkg;

    localparam int AW    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 2;

    localparam logic [IW-1:0] NOP = 16'h0000;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instr} with flush.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entries_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i & (cnt_q != 2'd0);
    assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            entries_q[0] <= '0;
            entries_q[1] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                entries_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign occ_o  = cnt_q;
    assign head_o = entries_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one program-memory read per cycle while the queue has room,
// buffers returned words tagged with their PC, and steers the PC on redirects.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc_in,
    output logic          pc_en,
    output logic          pc_load_en,
    output logic [AW-1:0] pc_load,
    output logic          imem_rd_en,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redir_en,
    input  logic [AW-1:0] redir_addr,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [IW-1:0] ir_out,
    output logic [AW-1:0] ir_pc
);

    logic          inflight_q;
    logic          inflight_d;
    logic [AW-1:0] inflight_pc_q;
    logic [AW-1:0] inflight_pc_d;
    logic          discard_q;
    logic          discard_d;

    logic [1:0]    occ;
    logic [2:0]    committed;
    logic          pop;
    logic          push;
    logic          issue;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign ir_valid  = (occ != 2'd0);
    assign pop       = ir_valid & ir_ready;
    assign committed = {1'b0, occ} + {2'b00, inflight_q};

    // Count the pop as freeing a slot so a ready consumer sees one word per cycle.
    assign issue = fetch_en & ~redir_en & ~reset & (committed < (3'(DEPTH) + {2'b00, pop}));

    // A response arriving while a redirect flushes belongs to the old stream.
    assign push = inflight_q & ~discard_q & ~redir_en & ~reset;

    assign imem_rd_en = issue;
    assign pc_en      = issue;
    assign imem_addr  = pc_in;
    assign pc_load_en = redir_en & ~reset;
    assign pc_load    = pc_load_en ? redir_addr : '0;

    always_comb begin
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_in : inflight_pc_q;
        discard_d     = redir_en & inflight_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imem_rdata;

    fetch_queue u_queue (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redir_en),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign ir_out = head.instr;
    assign ir_pc  = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: program memory and PC models, directed scenarios,
// then randomized traffic checked against the sequential-program-order stream.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redir_en = 1'b0;
    logic [AW-1:0] redir_addr = '0;
    logic          ir_ready = 1'b0;
    logic [AW-1:0] pc_in;
    logic          pc_en;
    logic          pc_load_en;
    logic [AW-1:0] pc_load;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = NOP;
    logic          ir_valid;
    logic [IW-1:0] ir_out;
    logic [AW-1:0] ir_pc;

    logic [IW-1:0]    mem [256];
    logic [AW-1:0]    pc_q = '0;
    logic [AW+IW-1:0] exp_q [$];
    logic [AW-1:0]    model_pc = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int outstanding = 0;
    int n_pop = 0;
    int n_issue = 0;
    int first_issue = -1;
    int first_valid = -1;

    logic             mon_pop;
    logic             mon_exp_issue;
    logic [AW+IW-1:0] mon_e;
    logic             prev_hold = 1'b0;
    logic             prev_redir = 1'b0;
    logic             prev_rst = 1'b0;
    logic [AW+IW-1:0] prev_head = '0;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .pc_in      (pc_in),
        .pc_en      (pc_en),
        .pc_load_en (pc_load_en),
        .pc_load    (pc_load),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redir_en   (redir_en),
        .redir_addr (redir_addr),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_out     (ir_out),
        .ir_pc      (ir_pc)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- environment models ----------------
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        else            imem_rdata <= IW'($urandom);
    end

    always @(posedge clk) begin
        if (reset)           pc_q <= '0;
        else if (pc_load_en) pc_q <= pc_load;
        else if (pc_en)      pc_q <= pc_q + 1'b1;
    end
    assign pc_in = pc_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic fe, input logic rdy,
                         input logic rd, input logic [AW-1:0] ra);
        @(negedge clk);
        reset      = rst;
        fetch_en   = fe;
        ir_ready   = rdy;
        redir_en   = rd;
        redir_addr = ra;
        if (rst) begin
            exp_q.delete();
            model_pc = '0;
        end else begin
            if (rd) begin
                exp_q.delete();
                model_pc = ra;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({model_pc, mem[model_pc]});
                model_pc = model_pc + 1'b1;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (reset) begin
            check("rst_pc_en", 32'(pc_en), 32'd0);
            check("rst_rd_en", 32'(imem_rd_en), 32'd0);
            check("rst_load_en", 32'(pc_load_en), 32'd0);
            outstanding = 0;
            prev_hold   = 1'b0;
        end else begin
            mon_pop = ir_valid & ir_ready;
            check("addr_eq_pc", 32'(imem_addr), 32'(pc_in));
            check("load_en", 32'(pc_load_en), 32'(redir_en));
            if (redir_en) check("load_val", 32'(pc_load), 32'(redir_addr));
            mon_exp_issue = fetch_en && !redir_en && ((outstanding - int'(mon_pop)) < DEPTH);
            check("issue", 32'(imem_rd_en), 32'(mon_exp_issue));
            check("pc_en", 32'(pc_en), 32'(mon_exp_issue));
            if (prev_rst) begin
                check("post_rst_valid", 32'(ir_valid), 32'd0);
                check("post_rst_out", 32'(ir_out), 32'd0);
                check("post_rst_pc", 32'(ir_pc), 32'd0);
            end
            if (prev_redir) check("flush_valid", 32'(ir_valid), 32'd0);
            if (prev_hold) begin
                check("hold_valid", 32'(ir_valid), 32'd1);
                check("hold_data", 32'({ir_pc, ir_out}), 32'(prev_head));
            end
            if (mon_pop && !redir_en) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("head_pc", 32'(ir_pc), 32'(mon_e[IW +: AW]));
                    check("head_instr", 32'(ir_out), 32'(mon_e[IW-1:0]));
                end
            end
            if (redir_en) outstanding = 0;
            else          outstanding = outstanding + int'(imem_rd_en) - int'(mon_pop);
            if (imem_rd_en) n_issue++;
            if (imem_rd_en && first_issue < 0) first_issue = cyc;
            if (ir_valid && first_valid < 0) first_valid = cyc;
            prev_hold = ir_valid & ~ir_ready & ~redir_en;
            prev_head = {ir_pc, ir_out};
        end
        prev_redir = redir_en & ~reset;
        prev_rst   = reset;
    end

    // ---------------- stimulus ----------------
    initial begin
        int snap_pop;
        int snap_issue;
        for (int i = 0; i < 256; i++) mem[i] = {8'hA0, 8'(i)};

        // Back-to-back fetch with a always-ready consumer.
        repeat (2) drive(1, 0, 0, 0, '0);
        repeat (5) drive(0, 1, 1, 0, '0);
        check("first_latency", 32'(first_valid - first_issue), 32'd2);
        snap_pop = n_pop;
        repeat (40) drive(0, 1, 1, 0, '0);
        check("throughput", 32'(n_pop - snap_pop), 32'd40);

        // Consumer stalled: exactly two reads outstanding, PC holds at 2.
        repeat (2) drive(1, 0, 0, 0, '0);
        snap_issue = n_issue;
        repeat (8) drive(0, 1, 0, 0, '0);
        #3;
        check("stall_issues", 32'(n_issue - snap_issue), 32'd2);
        check("stall_pc", 32'(pc_q), 32'd2);
        check("stall_head", 32'(ir_out), 32'hA000);
        snap_pop = n_pop;
        repeat (6) drive(0, 1, 1, 0, '0);
        check("stall_drain", 32'(n_pop - snap_pop) >= 32'd4, 32'd1);

        // Redirect with one read in flight and one word queued.
        repeat (2) drive(1, 0, 0, 0, '0);
        repeat (2) drive(0, 1, 0, 0, '0);
        drive(0, 1, 0, 1, 8'h40);
        snap_pop = n_pop;
        repeat (6) drive(0, 1, 1, 0, '0);
        check("redir_pops", 32'(n_pop - snap_pop) >= 32'd3, 32'd1);

        // Address wrap after a redirect to the top of memory.
        drive(0, 1, 1, 1, 8'hFF);
        snap_pop = n_pop;
        repeat (6) drive(0, 1, 1, 0, '0);
        check("wrap_pops", 32'(n_pop - snap_pop) >= 32'd3, 32'd1);

        // Halt right after one issue: the in-flight word still arrives.
        repeat (2) drive(1, 0, 0, 0, '0);
        snap_issue = n_issue;
        snap_pop   = n_pop;
        drive(0, 1, 1, 0, '0);
        repeat (6) drive(0, 0, 1, 0, '0);
        check("halt_issues", 32'(n_issue - snap_issue), 32'd1);
        check("halt_pops", 32'(n_pop - snap_pop), 32'd1);
        repeat (6) drive(0, 1, 1, 0, '0);

        // Reset with the queue full, then restart from PC 0.
        repeat (6) drive(0, 1, 0, 0, '0);
        drive(1, 1, 0, 0, '0);
        repeat (6) drive(0, 1, 1, 0, '0);

        // Randomized traffic over random program contents.
        repeat (2) drive(1, 0, 0, 0, '0);
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0),
                  AW'($urandom));
        end
        repeat (2) drive(0, 0, 1, 0, '0);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
